// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: shares one my_ip_send UDP transmitter between NUM_CH
// frame requesters. Round-robin grant, one-clock send_en, latched byte
// count, read-strobe forwarding, completion/timeout reporting and a fixed
// inter-frame gap before the next grant.
module udp_tx_scheduler #(
    parameter int          NUM_CH         = 4,
    parameter int          IFG_CYCLES     = 24,
    parameter int          MAX_BYTES      = 1472,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8191
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH*16-1:0]      ch_len,
    input  logic [NUM_CH*32-1:0]      ch_data,
    output logic [NUM_CH-1:0]         ch_rd,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [NUM_CH-1:0]         ch_err,
    output logic                      send_en,
    output logic [31:0]               send_data,
    output logic [15:0]               send_data_num,
    input  logic                      read_data_req,
    input  logic                      send_end,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id
);

    localparam int GID_W = $clog2(NUM_CH);
    // One extra bit so rr_ptr + k (k up to NUM_CH) never overflows before the wrap
    localparam int CW    = GID_W + 1;

    localparam logic [15:0] MAX_LEN      = 16'(MAX_BYTES);
    localparam logic [15:0] IFG_LAST     = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] START    = 2'd1;
    localparam logic [1:0] WAIT_END = 2'd2;
    localparam logic [1:0] GAP      = 2'd3;

    logic [1:0]        state_reg;
    logic [GID_W-1:0]  grant_id_reg;
    logic [GID_W-1:0]  rr_ptr_reg;
    logic [15:0]       send_data_num_reg;
    logic [15:0]       tmo_cnt_reg;
    logic [15:0]       gap_cnt_reg;
    logic [NUM_CH-1:0] ch_done_reg;
    logic [NUM_CH-1:0] ch_err_reg;

    logic [15:0]       len_arr  [NUM_CH];
    logic [31:0]       data_arr [NUM_CH];

    logic              sel_found;
    logic [GID_W-1:0]  sel_idx;
    logic [CW-1:0]     cand;
    logic [15:0]       sel_len;
    logic              sel_legal;
    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] grant_oh;
    logic              in_frame;

    // Unpack the flat per-channel buses into indexable arrays
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign len_arr[gi]  = ch_len[16*gi +: 16];
            assign data_arr[gi] = ch_data[32*gi +: 32];
        end
    endgenerate

    // Round-robin search: first requester after rr_ptr, wrapping at NUM_CH
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, rr_ptr_reg} + CW'(k);
            if (cand >= CW'(NUM_CH)) begin
                cand = cand - CW'(NUM_CH);
            end
            if (!sel_found && ch_req[cand[GID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GID_W-1:0];
            end
        end
    end

    assign sel_len   = len_arr[sel_idx];
    assign sel_legal = (sel_len != 16'd0) && (sel_len <= MAX_LEN);
    assign sel_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << sel_idx;
    assign grant_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_id_reg;
    assign in_frame  = (state_reg == START) || (state_reg == WAIT_END);

    // Frame sequencer: grant, start pulse, wait for end/timeout, gap
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg         <= IDLE;
            grant_id_reg      <= '0;
            rr_ptr_reg        <= GID_W'(NUM_CH - 1);
            send_data_num_reg <= '0;
            tmo_cnt_reg       <= '0;
            gap_cnt_reg       <= '0;
            ch_done_reg       <= '0;
            ch_err_reg        <= '0;
        end else begin
            ch_done_reg <= '0;
            ch_err_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        grant_id_reg <= sel_idx;
                        // Pointer moves even on reject so a bad channel cannot starve others
                        rr_ptr_reg   <= sel_idx;
                        if (sel_legal) begin
                            send_data_num_reg <= sel_len;
                            tmo_cnt_reg       <= '0;
                            state_reg         <= START;
                        end else begin
                            ch_err_reg <= sel_oh;
                        end
                    end
                end
                START: begin
                    // tmo_cnt_reg tracks clocks elapsed since the send_en clock
                    tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    state_reg   <= WAIT_END;
                end
                WAIT_END: begin
                    // send_end is tested first so it wins over a coincident timeout
                    if (send_end) begin
                        ch_done_reg <= grant_oh;
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                        ch_err_reg  <= grant_oh;
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == IFG_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign send_en       = (state_reg == START);
    assign busy          = (state_reg != IDLE);
    assign ch_rd         = (read_data_req && in_frame) ? grant_oh : '0;
    assign send_data     = data_arr[grant_id_reg];
    assign send_data_num = send_data_num_reg;
    assign grant_id      = grant_id_reg;
    assign ch_done       = ch_done_reg;
    assign ch_err        = ch_err_reg;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench for udp_tx_scheduler. Each round builds a frame-level
// timeline (grant order, send_en clock, outcome clock, busy window) from the
// arbitration and timing rules, then drives a my_ip_send/channel model and
// compares the DUT against that timeline every clock.
module tb_udp_tx_scheduler;

    localparam int NUM_CH = 4;
    localparam int IFG    = 24;
    localparam int MAXB   = 1472;
    localparam int TMO    = 100;
    localparam int MAXC   = 2048;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*16-1:0] ch_len;
    logic [NUM_CH*32-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_rd;
    logic [NUM_CH-1:0]    ch_done;
    logic [NUM_CH-1:0]    ch_err;
    logic                 send_en;
    logic [31:0]          send_data;
    logic [15:0]          send_data_num;
    logic                 read_data_req;
    logic                 send_end;
    logic                 busy;
    logic [1:0]           grant_id;

    always #5 sys_clk = ~sys_clk;

    udp_tx_scheduler #(
        .NUM_CH        (NUM_CH),
        .IFG_CYCLES    (IFG),
        .MAX_BYTES     (MAXB),
        .TIMEOUT_CYCLES(16'(TMO))
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .ch_req        (ch_req),
        .ch_len        (ch_len),
        .ch_data       (ch_data),
        .ch_rd         (ch_rd),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .send_en       (send_en),
        .send_data     (send_data),
        .send_data_num (send_data_num),
        .read_data_req (read_data_req),
        .send_end      (send_end),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    int tests = 0;
    int fails = 0;
    int m_ptr;

    // Per-round channel setup
    logic [15:0] r_len  [NUM_CH];
    int          r_dly  [NUM_CH];   // clocks from send_en to send_end; 0 = never
    logic [31:0] r_data [NUM_CH];
    bit          rd_once;

    // Expected timeline, indexed by clock within the round
    bit                exp_en   [MAXC];
    bit                exp_busy [MAXC];
    logic [NUM_CH-1:0] exp_done [MAXC];
    logic [NUM_CH-1:0] exp_err  [MAXC];
    int                win_ch   [MAXC];
    int                en_ch    [MAXC];
    bit                drv_end  [MAXC];
    bit                drv_rd   [MAXC];

    function automatic logic [NUM_CH-1:0] onehot(input int ch);
        return NUM_CH'(1) << ch;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_len[16*i +: 16]  = r_len[i];
            ch_data[32*i +: 32] = r_data[i];
        end
    endtask

    task automatic run_round(input logic [NUM_CH-1:0] mask);
        int t, sel, en, outc, last;
        logic [NUM_CH-1:0] m;
        logic [NUM_CH-1:0] exp_rd;
        for (int c = 0; c < MAXC; c++) begin
            exp_en[c] = 0; exp_busy[c] = 0; exp_done[c] = '0; exp_err[c] = '0;
            win_ch[c] = -1; en_ch[c] = -1; drv_end[c] = 0;
            drv_rd[c] = rd_once ? 1'b0 : 1'($urandom_range(0, 1));
        end
        // Build the frame timeline from the arbitration rules
        m = mask;
        t = 0;
        while (m != '0) begin
            sel = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int c = (m_ptr + k) % NUM_CH;
                if (sel < 0 && (m & onehot(c)) != '0) sel = c;
            end
            m_ptr = sel;
            m = m & ~onehot(sel);
            if (r_len[sel] == 16'd0 || int'(r_len[sel]) > MAXB) begin
                exp_err[t+1] = exp_err[t+1] | onehot(sel);
                t = t + 1;
            end else begin
                en = t + 1;
                exp_en[en] = 1;
                en_ch[en]  = sel;
                if (rd_once) drv_rd[en+1] = 1;
                if (r_dly[sel] > 0) drv_end[en + r_dly[sel]] = 1;
                if (r_dly[sel] > 0 && r_dly[sel] < TMO) begin
                    outc = en + r_dly[sel] + 1;
                    exp_done[outc] = exp_done[outc] | onehot(sel);
                end else begin
                    outc = en + TMO;
                    exp_err[outc] = exp_err[outc] | onehot(sel);
                end
                for (int c = en; c < outc; c++) win_ch[c] = sel;
                for (int c = en; c < outc + IFG; c++) exp_busy[c] = 1;
                t = outc + IFG;
            end
        end
        last = t;
        // Drive the channels and my_ip_send model, compare every clock
        for (int c = 0; c <= last; c++) begin
            @(negedge sys_clk);
            if (c == 0) begin
                drive_bus();
                ch_req = mask;
            end
            send_end      = drv_end[c];
            read_data_req = drv_rd[c];
            if (exp_en[c] && $urandom_range(0, 1) == 1) begin
                // Post-grant length change and request drop must be ignored
                ch_len[16*en_ch[c] +: 16] = 16'($urandom);
                ch_req = ch_req & ~onehot(en_ch[c]);
            end
            #1;
            check($sformatf("outs c%0d", c),
                  64'({busy, send_en, ch_done, ch_err}),
                  64'({exp_busy[c], exp_en[c], exp_done[c], exp_err[c]}));
            exp_rd = (drv_rd[c] && win_ch[c] >= 0) ? onehot(win_ch[c]) : '0;
            check($sformatf("ch_rd c%0d", c), 64'(ch_rd), 64'(exp_rd));
            if (exp_rd != '0)
                check($sformatf("send_data c%0d", c), 64'(send_data), 64'(r_data[win_ch[c]]));
            if (exp_en[c]) begin
                check($sformatf("grant_id c%0d", c), 64'(grant_id), 64'(en_ch[c]));
                check($sformatf("send_data_num c%0d", c), 64'(send_data_num), 64'(r_len[en_ch[c]]));
                $display("[TB] c%0d send_en grant=%0d len=%0d", c, grant_id, send_data_num);
            end
            if ((ch_done | ch_err) != '0)
                $display("[TB] c%0d done=%b err=%b", c, ch_done, ch_err);
            ch_req = ch_req & ~(ch_done | ch_err);
        end
        ch_req        = '0;
        send_end      = 1'b0;
        read_data_req = 1'b0;
    endtask

    initial begin
        bit found;
        int k;

        // Reset
        sys_rst_n = 1'b0; ch_req = '0; ch_len = '0; ch_data = '0;
        send_end = 1'b0; read_data_req = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            r_len[i] = 16'd8; r_dly[i] = 8; r_data[i] = $urandom;
        end
        rd_once = 0;
        repeat (3) @(negedge sys_clk);
        #1;
        check("reset outs", 64'({busy, send_en, ch_done, ch_err, ch_rd}), 64'd0);
        check("reset grant_id", 64'(grant_id), 64'd0);
        check("reset send_data_num", 64'(send_data_num), 64'd0);
        sys_rst_n = 1'b1; read_data_req = 1'b0;
        m_ptr = NUM_CH - 1;

        // Single frame, one read, send_end 60 clocks after send_en
        r_len[0] = 16'd3; r_dly[0] = 60; rd_once = 1;
        run_round(4'b0001);
        rd_once = 0;

        // Round robin, all lengths 8: grants 0,1,2,3 then 0,1,2,3
        for (int i = 0; i < NUM_CH; i++) begin r_len[i] = 16'd8; r_dly[i] = 8; end
        run_round(4'b1111);
        run_round(4'b1111);

        // Length reject: channel 1 too long, channel 2 zero
        r_len[1] = 16'd1473; r_len[2] = 16'd0;
        run_round(4'b0110);

        // Timeout on channel 0, then normal grant of channel 2
        r_len[0] = 16'd5; r_dly[0] = 0; r_len[2] = 16'd5; r_dly[2] = 10;
        run_round(4'b0101);

        // send_end on the timeout clock wins; send_end one clock late is ignored
        r_len[3] = 16'd1472; r_dly[3] = TMO - 1; r_len[1] = 16'd1; r_dly[1] = TMO;
        run_round(4'b1010);

        // Reset mid-frame
        for (int i = 0; i < NUM_CH; i++) begin r_len[i] = 16'd10; r_dly[i] = 12; end
        drive_bus();
        @(negedge sys_clk);
        ch_req = 4'b0010;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge sys_clk);
            #1;
            if (send_en) found = 1;
        end
        check("rst test send_en seen", 64'(found), 64'd1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0; read_data_req = 1'b1;
        @(negedge sys_clk);
        #1;
        check("midframe reset outs", 64'({busy, send_en, ch_done, ch_err, ch_rd}), 64'd0);
        check("midframe reset grant_id", 64'(grant_id), 64'd0);
        check("midframe reset send_data_num", 64'(send_data_num), 64'd0);
        sys_rst_n = 1'b1; ch_req = '0; read_data_req = 1'b0;
        @(negedge sys_clk);
        send_end = 1'b1;
        @(negedge sys_clk);
        send_end = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("post reset quiet %0d", i),
                  64'({busy, send_en, ch_done, ch_err}), 64'd0);
            @(negedge sys_clk);
        end
        m_ptr = NUM_CH - 1;
        run_round(4'b0011);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                k = $urandom_range(0, 9);
                case (k)
                    0:       r_len[i] = 16'd0;
                    1:       r_len[i] = 16'd1;
                    2:       r_len[i] = 16'd1472;
                    3:       r_len[i] = 16'd1473;
                    4:       r_len[i] = 16'hFFFF;
                    default: r_len[i] = 16'($urandom_range(1, 1472));
                endcase
                k = $urandom_range(0, 9);
                case (k)
                    0:       r_dly[i] = 0;
                    1:       r_dly[i] = TMO - 1;
                    2:       r_dly[i] = TMO;
                    3:       r_dly[i] = 1;
                    default: r_dly[i] = $urandom_range(2, 70);
                endcase
                r_data[i] = $urandom;
            end
            run_round(NUM_CH'($urandom_range(1, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Shares one my_ip_send UDP transmitter between NUM_CH frame requesters, using round-robin arbitration.
- Sequences each frame: grant, send_en pulse, byte-count load, data-read forwarding, completion and inter-frame gap.
- Sits between the application-side channel buffers and the my_ip_send / crc32_d4 pair, in the eth_tx_clk domain.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
IFG_CYCLES, 24, idle clocks enforced after each frame (12 bytes at 4 bits/clk)
MAX_BYTES, 1472, largest legal UDP payload in bytes
TIMEOUT_CYCLES, 16'd8191, maximum clocks from send_en to send_end before abort

Ports:
sys_clk  in  1  transmit clock (eth_tx_clk)
sys_rst_n  in  1  synchronous active-low reset
ch_req  in  NUM_CH  per-channel level request; held until ch_done or ch_err
ch_len  in  NUM_CH*16  per-channel payload byte count; channel i occupies bits [16i+15:16i]
ch_data  in  NUM_CH*32  per-channel payload word; channel i occupies bits [32i+31:32i]
ch_rd  out  NUM_CH  read strobe to the granted channel (one-hot)
ch_done  out  NUM_CH  1-clk pulse when the channel's frame completes
ch_err  out  NUM_CH  1-clk pulse on length reject or timeout
send_en  out  1  1-clk frame start to my_ip_send
send_data  out  32  payload word to my_ip_send
send_data_num  out  16  payload byte count to my_ip_send
read_data_req  in  1  word request from my_ip_send
send_end  in  1  frame-finished pulse from my_ip_send
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_CH)  index of the current or last granted channel

Behaviour:
- Reset is sampled on sys_clk only.
- Reset values:
  - state = IDLE.
  - send_en, ch_rd, ch_done, ch_err and busy = 0.
  - send_data_num = 0; grant_id = 0; rr_ptr = NUM_CH-1, so channel 0 has first priority.
  - All counters = 0.
- Reset asserted mid-frame returns the block to IDLE immediately. No ch_done is issued for the interrupted frame.
- FSM states: IDLE, START, WAIT_END, GAP.
- IDLE:
  - If any ch_req bit is high, select the first requester searching from rr_ptr+1 with wrap-around.
  - Register grant_id = selected index and rr_ptr = selected index.
  - Legal length (1 <= ch_len[sel] <= MAX_BYTES):
    - Register send_data_num = ch_len[sel].
    - Go to START.
  - Illegal length (0 or > MAX_BYTES):
    - Pulse ch_err[sel] on the next clock.
    - Stay in IDLE. The pointer has already advanced, so other requesters are not starved.
- START:
  - send_en = 1 for exactly this one clock.
  - Timeout counter is cleared.
  - Next state is WAIT_END.
- Latency: a request seen in IDLE at edge t gives send_en high in the cycle after edge t.
- WAIT_END:
  - Timeout counter increments each clock.
  - send_end = 1: pulse ch_done[grant_id] for one clock, then go to GAP.
  - Counter reaches TIMEOUT_CYCLES without send_end: pulse ch_err[grant_id], then go to GAP.
  - send_end and timeout on the same clock: send_end wins (done, no err).
- GAP:
  - Count IFG_CYCLES clocks, then go to IDLE.
  - The gap clocks are not extended by new requests.
- Data path:
  - ch_rd = read_data_req ? onehot(grant_id) : 0, combinational. It is only active in START or WAIT_END; otherwise it is 0.
  - send_data = ch_data[grant_id], combinational mux.
  - The channel must register its word on the clock that ch_rd is high, matching my_ip_send timing.
- Other inputs:
  - send_end and read_data_req arriving in IDLE or GAP are ignored.
  - ch_req deasserted mid-frame is ignored; the frame runs to send_end or timeout.
  - ch_len changes after grant are ignored; the count is latched.
- busy = 1 in START, WAIT_END and GAP.

Test Plan:
- Single frame: ch_req=0001, ch_len[0]=3; model my_ip_send asserts read_data_req once, then send_end 60 clocks later.
  - Required: send_en 1-clk pulse, send_data_num=3, ch_rd=0001 once.
  - Required: ch_done[0] one clock after send_end; busy low exactly 24 clocks after done.
- Round robin: ch_req=1111 held, all lengths 8.
  - Required: grant order 0,1,2,3,0.
  - Required: successive send_en pulses separated by frame length + 24 + 2 clocks; exactly one ch_done per frame.
- Length reject: ch_len[2]=0 and ch_len[1]=1473 with ch_req=0110.
  - Required: ch_err[1] pulse, then ch_err[2] pulse; no send_en at all; busy stays 0.
- Timeout: TIMEOUT_CYCLES=100, send_end never asserted.
  - Required: ch_err[grant] pulse 100 clocks after send_en; no ch_done; then GAP, then next grant.
- Simultaneous send_end and timeout: send_end placed on the timeout clock.
  - Required: ch_done pulse, ch_err stays 0.
- Reset mid-frame: sys_rst_n low for 1 clk during WAIT_END.
  - Required: all outputs 0 and grant_id=0 on the next clock.
  - Required: a later send_end produces no ch_done; the next grant goes to channel 0.
